// File: rtl/pool2d_stream.sv
// Streaming KxK, stride-K 2-D pooling engine with a one-row partial-result buffer.
// Define POOL_AVG_EN to add the mode port and the average-pooling path.
module pool2d_stream #(
  parameter int unsigned DW     = 16,
  parameter int unsigned IN_DIM = 6,
  parameter int unsigned K      = 2,
  parameter int unsigned AW     = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
`ifdef POOL_AVG_EN
  input  logic          mode_i,
`endif
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [AW-1:0] out_addr_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned LK  = $clog2(K);
  localparam int unsigned NWC = IN_DIM / K;
  localparam int unsigned CW  = $clog2(IN_DIM);
  localparam int unsigned WcW = (NWC > 1) ? $clog2(NWC) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned AccW = DW + 2 * LK;
`else
  localparam int unsigned AccW = DW;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  state_e state_q, state_d;

  logic [CW-1:0]   col_q, col_d, row_q, row_d;
  logic [AccW-1:0] acc_q [NWC];
  logic [AccW-1:0] acc_d [NWC];
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
`ifdef POOL_AVG_EN
  logic            mode_q, mode_d;
`endif

  logic            accept, out_hs, start_ok, last_pix, win_first, win_last;
  logic [WcW-1:0]  wc;
  logic [AccW-1:0] cur, din, comb_val;
  logic [DW-1:0]   res;

  assign start_ok  = (state_q == StIdle) && start_i;
  assign accept    = in_valid_i && in_ready_o;
  assign out_hs    = out_valid_q && out_ready_i;
  assign last_pix  = (row_q == CW'(IN_DIM - 1)) && (col_q == CW'(IN_DIM - 1));
  assign win_first = (row_q[LK-1:0] == '0) && (col_q[LK-1:0] == '0);
  assign win_last  = (row_q[LK-1:0] == '1) && (col_q[LK-1:0] == '1);
  assign wc        = WcW'(col_q >> LK);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (accept && last_pix) state_d = StDrain;
      StDrain: if (out_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o     = (state_q != StIdle);
    in_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
  end

  always_comb begin
    acc_d       = acc_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    cur         = acc_q[wc];
    din         = AccW'(in_data_i);
`ifdef POOL_AVG_EN
    mode_d      = mode_q;
    if (mode_q) begin
      comb_val = cur + din;
      res      = DW'(comb_val >> (2 * LK));
    end else begin
      comb_val = (din > cur) ? din : cur;
      res      = DW'(comb_val);
    end
`else
    comb_val    = (din > cur) ? din : cur;
    res         = DW'(comb_val);
`endif

    if (start_ok) begin
      col_d = '0;
      row_d = '0;
      cnt_d = '0;
`ifdef POOL_AVG_EN
      mode_d = mode_i;
`endif
    end

    if (accept) begin
      acc_d[wc] = win_first ? din : comb_val;
      if (col_q == CW'(IN_DIM - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(IN_DIM - 1)) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // A free or just-drained register is guaranteed whenever accept is high.
      if (win_last) begin
        out_valid_d = 1'b1;
        out_data_d  = res;
      end
    end

    if (out_hs) begin
      if (state_q == StDrain) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NWC); i++) acc_q[i] <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
`ifdef POOL_AVG_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
`ifdef POOL_AVG_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = cnt_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed + randomized bench for pool2d_stream: a 6x6/K=2 instance and an 8x8/K=4 instance,
// checked against a window-by-window reference model.
module tb_pool2d_stream;

  logic        clk = 1'b0;
  logic        rst_n, start_a, start_b, in_valid, out_ready;
  logic [15:0] in_data;
`ifdef POOL_AVG_EN
  logic        mode;
`endif

  logic        a_in_ready, a_out_valid, a_busy, a_done;
  logic [15:0] a_out_data;
  logic [7:0]  a_out_addr;
  logic        b_in_ready, b_out_valid, b_busy, b_done;
  logic [15:0] b_out_data;
  logic [7:0]  b_out_addr;

  logic        sel;
  logic        o_in_ready, o_out_valid, o_busy, o_done;
  logic [15:0] o_out_data;
  logic [7:0]  o_out_addr;

  int n_assert = 0;
  int n_fail   = 0;
  int pix[64];
  int exp_q[$];

  always #5 clk = ~clk;

  pool2d_stream #(.DW(16), .IN_DIM(6), .K(2), .AW(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
`ifdef POOL_AVG_EN
    .mode_i(mode),
`endif
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
    .out_addr_o(a_out_addr), .busy_o(a_busy), .done_o(a_done)
  );

  pool2d_stream #(.DW(16), .IN_DIM(8), .K(4), .AW(8)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
`ifdef POOL_AVG_EN
    .mode_i(mode),
`endif
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
    .out_addr_o(b_out_addr), .busy_o(b_busy), .done_o(b_done)
  );

  always_comb begin
    o_in_ready  = sel ? b_in_ready  : a_in_ready;
    o_out_valid = sel ? b_out_valid : a_out_valid;
    o_out_data  = sel ? b_out_data  : a_out_data;
    o_out_addr  = sel ? b_out_addr  : a_out_addr;
    o_busy      = sel ? b_busy      : a_busy;
    o_done      = sel ? b_done      : a_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: each KxK window reduced independently, results in window raster order.
  task automatic build_exp(input int dim, input int k, input bit avg);
    int v, p;
    exp_q.delete();
    for (int wr = 0; wr < dim / k; wr++) begin
      for (int wcol = 0; wcol < dim / k; wcol++) begin
        v = 0;
        for (int r = 0; r < k; r++) begin
          for (int c = 0; c < k; c++) begin
            p = pix[(wr * k + r) * dim + wcol * k + c];
            if (avg) v += p;
            else if (p > v) v = p;
          end
        end
        exp_q.push_back(avg ? v / (k * k) : v);
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_out_valid"}, {31'd0, o_out_valid}, 32'd0);
    check({tag, "_out_data"}, {16'd0, o_out_data}, 32'd0);
    check({tag, "_out_addr"}, {24'd0, o_out_addr}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, o_done}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd0);
  endtask

  // Called and returns on a negedge; the start pulse is raised in the calling cycle.
  task automatic run_frame(input bit s, input int dim, input int k, input bit avg,
                           input int stall, input bit gaps, input int abort_at,
                           input int start_mid);
    int n, nout, idx, got, wait_c, cyc;
    bit hold;
    logic [15:0] hd;
    logic [7:0]  ha;
    n = dim * dim;
    nout = (dim / k) * (dim / k);
    build_exp(dim, k, avg);
    sel = s;
`ifdef POOL_AVG_EN
    mode = avg;
`endif
    if (s) start_b = 1'b1; else start_a = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    idx = 0; got = 0; wait_c = 0; cyc = 0; hold = 1'b0; hd = '0; ha = '0;
    while (got < nout && cyc < 5000) begin
      cyc++;
      if (abort_at > 0 && idx == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_no_done", {31'd0, o_done}, 32'd0);
        return;
      end
      if (s) start_b = (idx == start_mid); else start_a = (idx == start_mid);
      in_valid  = (idx < n) && (!gaps || $urandom_range(3) != 0);
      in_data   = (idx < n) ? pix[idx][15:0] : 16'h0;
      out_ready = (stall == 0) || (wait_c >= stall);
      #1;
      if (hold) begin
        check("hold_data", {16'd0, o_out_data}, {16'd0, hd});
        check("hold_addr", {24'd0, o_out_addr}, {24'd0, ha});
      end
      hold = 1'b0;
      if (o_out_valid && !out_ready) begin
        wait_c++;
        hold = 1'b1;
        hd = o_out_data;
        ha = o_out_addr;
        check("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
      end
      if (o_out_valid && out_ready) begin
        check("out_data", {16'd0, o_out_data}, exp_q[got]);
        check("out_addr", {24'd0, o_out_addr}, got);
        check("done_early", {31'd0, o_done}, 32'd0);
        got++;
        wait_c = 0;
      end
      if (in_valid && o_in_ready) idx++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    check("frame_results", got, nout);
    check("frame_samples", idx, n);
    check("done_pulse", {31'd0, o_done}, 32'd1);
    check("busy_end", {31'd0, o_busy}, 32'd0);
    check("addr_end", {24'd0, o_out_addr}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_data = '0; sel = 1'b0;
`ifdef POOL_AVG_EN
    mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_idle_zero("reset_a");
    sel = 1'b1;
    #1;
    check_idle_zero("reset_b");
    sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Samples offered while idle must be refused and change nothing.
    in_valid = 1'b1;
    repeat (3) begin
      #1;
      check("idle_in_ready", {31'd0, o_in_ready}, 32'd0);
      check("idle_busy", {31'd0, o_busy}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 36; i++) pix[i] = i;
    run_frame(1'b0, 6, 2, 1'b0, 0, 1'b0, 0, -1);
    run_frame(1'b0, 6, 2, 1'b0, 5, 1'b0, 0, -1);
`ifdef POOL_AVG_EN
    run_frame(1'b0, 6, 2, 1'b1, 0, 1'b0, 0, -1);
`endif
    run_frame(1'b0, 6, 2, 1'b0, 0, 1'b0, 20, -1);
    for (int i = 0; i < 36; i++) pix[i] = 100 + i;
    run_frame(1'b0, 6, 2, 1'b0, 0, 1'b0, 0, -1);
    run_frame(1'b0, 6, 2, 1'b0, 0, 1'b1, 0, 10);

    for (int i = 0; i < 36; i++) pix[i] = int'($urandom_range(16'hFFFF));
    run_frame(1'b0, 6, 2, 1'b0, 2, 1'b1, 0, -1);
`ifdef POOL_AVG_EN
    run_frame(1'b0, 6, 2, 1'b1, 1, 1'b1, 0, -1);
`endif

    for (int i = 0; i < 64; i++) pix[i] = 16'hFFFF;
    pix[$urandom_range(63)] = 0;
    run_frame(1'b1, 8, 4, 1'b0, 0, 1'b0, 0, -1);
    for (int i = 0; i < 64; i++) pix[i] = 16'hFFFF;
    pix[$urandom_range(63)] = 0;
    run_frame(1'b1, 8, 4, 1'b0, 0, 1'b0, 0, -1);
    for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(16'hFFFF));
    run_frame(1'b1, 8, 4, 1'b0, 3, 1'b1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
